// File: rtl/conv_seq_pkg.sv
// Shared types and helpers for the multi-layer convolution sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_START,
        S_MEM_WAIT,
        S_PE_START,
        S_PE_WAIT,
        S_DONE
    } state_e;

    function automatic int calc_lw(input int max_layers);
        return $clog2(max_layers + 1);
    endfunction

endpackage

// File: rtl/conv_done_collector.sv
// Sticky OR collector for per-channel done pulses; all_done_o also sees
// the current-cycle inputs so the last bit needs no extra cycle.
module conv_done_collector #(
    parameter int NUM_CH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              cap_i,
    input  logic [NUM_CH-1:0] in_i,
    output logic              all_done_o
);

    logic [NUM_CH-1:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = sticky_q;
        if (clr_i) begin
            sticky_d = '0;
        end else if (cap_i) begin
            sticky_d = sticky_q | in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign all_done_o = &(sticky_q | in_i);

endmodule

// File: rtl/conv_seq.sv
// Multi-layer load/PE sequencer for the convolution engine.
// Optional datapath watchdog: define CONV_SEQ_WATCHDOG_EN.
//
// state       | meaning
// ------------+---------------------------------------------
// S_IDLE      | waiting for start
// S_MEM_START | one-cycle start_mem strobe
// S_MEM_WAIT  | collecting all channel load-done bits
// S_PE_START  | one-cycle start_pe strobe (done_pe captured)
// S_PE_WAIT   | waiting for PE done
// S_DONE      | one-cycle run-complete strobe
module conv_seq
    import conv_seq_pkg::*;
#(
    parameter  int MAX_LAYERS = 4,
    parameter  int NUM_CH     = 4,
    parameter  int TIMEOUT    = 1024,
    localparam int LW         = calc_lw(MAX_LAYERS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LW-1:0]     num_layers,
    input  logic [NUM_CH-1:0] done_mem,
    input  logic              done_pe,
    output logic              start_mem,
    output logic              start_pe,
    output logic [LW-1:0]     layer,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e          state_q, state_d;
    logic [LW-1:0]   layer_q, layer_d;
    logic [LW-1:0]   n_q, n_d, n_lim;
    logic            pe_seen_q, pe_seen_d;
    logic            pe_hit;
    logic            mem_clr, mem_cap, all_done;
    logic            timeout;

    assign n_lim  = (num_layers > LW'(MAX_LAYERS)) ? LW'(MAX_LAYERS) : num_layers;
    assign pe_hit = done_pe | pe_seen_q;

    conv_done_collector #(.NUM_CH(NUM_CH)) u_collect (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (mem_clr),
        .cap_i      (mem_cap),
        .in_i       (done_mem),
        .all_done_o (all_done)
    );

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        n_d       = n_q;
        pe_seen_d = pe_seen_q;
        mem_clr   = 1'b0;
        mem_cap   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d     = n_lim;
                    layer_d = '0;
                    state_d = (n_lim == '0) ? S_DONE : S_MEM_START;
                end
            end
            S_MEM_START: begin
                mem_cap = 1'b1;
                state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                mem_cap = 1'b1;
                if (all_done) begin
                    mem_clr = 1'b1;
                    state_d = S_PE_START;
                end else if (timeout) begin
                    mem_clr = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_PE_START: begin
                pe_seen_d = done_pe;
                state_d   = S_PE_WAIT;
            end
            S_PE_WAIT: begin
                if (pe_hit) begin
                    pe_seen_d = 1'b0;
                    if (layer_q == n_q - LW'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + LW'(1);
                        state_d = S_MEM_START;
                    end
                end else if (timeout) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            layer_q   <= '0;
            n_q       <= '0;
            pe_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            n_q       <= n_d;
            pe_seen_q <= pe_seen_d;
        end
    end

`ifdef CONV_SEQ_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic           waiting;

    assign waiting = (state_q == S_MEM_WAIT) || (state_q == S_PE_WAIT);
    // Fires in the last permitted wait cycle, so DONE lands TIMEOUT cycles after entry.
    assign timeout = waiting && (wd_q == WDW'(TIMEOUT - 1));

    always_comb begin
        wd_d = '0;
        if (waiting && (state_d == state_q)) begin
            wd_d = wd_q + WDW'(1);
        end
        err_d = err_q;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if (timeout && (state_d == S_DONE) && !((state_q == S_PE_WAIT) && pe_hit)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT > 0);
    assign timeout            = 1'b0;
    assign err                = 1'b0;
`endif

    assign start_mem = (state_q == S_MEM_START);
    assign start_pe  = (state_q == S_PE_START);
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign layer     = layer_q;

endmodule

// File: tb/tb_conv_seq.sv
// Directed self-checking bench for conv_seq (MAX_LAYERS=4, NUM_CH=4, TIMEOUT=16).
module tb_conv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] num_layers;
    logic [3:0] done_mem;
    logic       done_pe;
    logic       start_mem, start_pe, busy, done, err;
    logic [2:0] layer;

    int vecs = 0;
    int miscompares = 0;
    int n_mem = 0, n_pe = 0, n_done = 0;

    conv_seq #(.MAX_LAYERS(4), .NUM_CH(4), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_layers (num_layers),
        .done_mem   (done_mem),
        .done_pe    (done_pe),
        .start_mem  (start_mem),
        .start_pe   (start_pe),
        .layer      (layer),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start_mem) n_mem++;
        if (start_pe)  n_pe++;
        if (done)      n_done++;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Responds to every strobe inside the strobe cycle; returns in the DONE cycle.
    task automatic auto_run(input logic [2:0] nl, input int budget, output bit timed_out);
        start = 1'b1;
        num_layers = nl;
        tick;
        start = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            done_mem = start_mem ? 4'b1111 : 4'b0000;
            done_pe  = start_pe;
            tick;
        end
        done_mem = '0;
        done_pe  = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; num_layers = '0; done_mem = '0; done_pe = 1'b0;
        #3;
        vecs++;
        if ({start_mem, start_pe, done, busy, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000", {start_mem, start_pe, done, busy, err});
        end
        vecs++;
        if (layer !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_layer: got %0d expected 0", layer);
        end
        repeat (2) tick;
        @(negedge clk);
        rst = 1'b0;
        tick;
        vecs++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_two_layer;
        int m0, p0, d0;
        m0 = n_mem; p0 = n_pe; d0 = n_done;
        num_layers = 3'd2; start = 1'b1;
        tick;
        start = 1'b0; num_layers = '0;
        vecs++;
        if ({start_mem, busy, layer} !== {1'b1, 1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL two_layer_start: got mem=%b busy=%b layer=%0d expected 1 1 0", start_mem, busy, layer);
        end
        for (int l = 0; l < 2; l++) begin
            tick;
            done_mem = 4'b0001; tick;
            done_mem = 4'b0100; tick;
            done_mem = 4'b1000; tick;
            done_mem = 4'b0010;
            vecs++;
            if (start_pe !== 1'b0) begin
                miscompares++;
                $display("FAIL two_layer_pe_early l%0d: got %b expected 0", l, start_pe);
            end
            tick;
            done_mem = '0;
            vecs++;
            if (start_pe !== 1'b1) begin
                miscompares++;
                $display("FAIL two_layer_pe_strobe l%0d: got %b expected 1", l, start_pe);
            end
            tick;
            done_pe = 1'b1;
            tick;
            done_pe = 1'b0;
            if (l == 0) begin
                vecs++;
                if ({start_mem, layer} !== {1'b1, 3'd1}) begin
                    miscompares++;
                    $display("FAIL two_layer_next: got mem=%b layer=%0d expected 1 1", start_mem, layer);
                end
            end else begin
                vecs++;
                if ({done, layer} !== {1'b1, 3'd1}) begin
                    miscompares++;
                    $display("FAIL two_layer_done: got done=%b layer=%0d expected 1 1", done, layer);
                end
            end
        end
        tick;
        vecs++;
        if ({busy, done, err} !== 3'b000) begin
            miscompares++;
            $display("FAIL two_layer_idle: got busy/done/err=%b expected 000", {busy, done, err});
        end
        vecs++;
        if ((n_mem - m0) != 2 || (n_pe - p0) != 2 || (n_done - d0) != 1) begin
            miscompares++;
            $display("FAIL two_layer_counts: got mem=%0d pe=%0d done=%0d expected 2 2 1", n_mem - m0, n_pe - p0, n_done - d0);
        end
    endtask

    task automatic test_same_cycle;
        num_layers = 3'd1; start = 1'b1;
        tick;
        start = 1'b0;
        done_mem = 4'b1111;
        tick;
        done_mem = '0;
        vecs++;
        if (start_pe !== 1'b0) begin
            miscompares++;
            $display("FAIL same_cycle_pe_plus1: got %b expected 0", start_pe);
        end
        tick;
        vecs++;
        if (start_pe !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_pe_plus2: got %b expected 1", start_pe);
        end
        tick;
        done_pe = 1'b1;
        tick;
        done_pe = 1'b0;
        vecs++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL same_cycle_done: got %b expected 1", done);
        end
        tick;
    endtask

    task automatic test_zero_layers;
        int m0, p0;
        m0 = n_mem; p0 = n_pe;
        num_layers = 3'd0; start = 1'b1;
        tick;
        start = 1'b0;
        vecs++;
        if ({done, busy, start_mem} !== 3'b110) begin
            miscompares++;
            $display("FAIL zero_layers_k1: got done/busy/mem=%b expected 110", {done, busy, start_mem});
        end
        tick;
        vecs++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL zero_layers_idle: got busy/done=%b expected 00", {busy, done});
        end
        vecs++;
        if ((n_mem - m0) != 0 || (n_pe - p0) != 0) begin
            miscompares++;
            $display("FAIL zero_layers_strobes: got mem=%0d pe=%0d expected 0 0", n_mem - m0, n_pe - p0);
        end
    endtask

    task automatic test_clamp;
        int m0, p0, d0;
        bit to;
        m0 = n_mem; p0 = n_pe; d0 = n_done;
        auto_run(3'd7, 100, to);
        vecs++;
        if (to !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_wait: got timeout expected done within 100 cycles");
        end
        vecs++;
        if (layer !== 3'd3) begin
            miscompares++;
            $display("FAIL clamp_last_layer: got %0d expected 3", layer);
        end
        tick;
        vecs++;
        if ((n_mem - m0) != 4 || (n_pe - p0) != 4 || (n_done - d0) != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clamp_counts: got mem=%0d pe=%0d done=%0d busy=%b expected 4 4 1 0", n_mem - m0, n_pe - p0, n_done - d0, busy);
        end
    endtask

    task automatic test_busy_stray;
        num_layers = 3'd1; start = 1'b1;
        tick;
        num_layers = 3'd3;
        tick;
        start = 1'b0;
        done_pe = 1'b1;
        tick;
        done_pe = 1'b0;
        vecs++;
        if ({start_pe, start_mem, busy} !== 3'b001) begin
            miscompares++;
            $display("FAIL stray_mem_wait: got pe/mem/busy=%b expected 001", {start_pe, start_mem, busy});
        end
        done_mem = 4'b1111;
        tick;
        done_mem = '0;
        vecs++;
        if (start_pe !== 1'b1) begin
            miscompares++;
            $display("FAIL stray_pe_strobe: got %b expected 1", start_pe);
        end
        tick;
        tick;
        vecs++;
        if ({done, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL stray_pe_wait_hold: got done/busy=%b expected 01", {done, busy});
        end
        done_pe = 1'b1;
        tick;
        done_pe = 1'b0;
        vecs++;
        if ({done, layer} !== {1'b1, 3'd0}) begin
            miscompares++;
            $display("FAIL stray_single_layer_done: got done=%b layer=%0d expected 1 0", done, layer);
        end
        tick;
        vecs++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stray_no_restart: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid;
        int d0, m0;
        bit to;
        num_layers = 3'd2; start = 1'b1;
        tick;
        start = 1'b0;
        done_mem = 4'b1111; tick;
        done_mem = '0;      tick;
        done_pe = 1'b1;     tick;
        done_pe = 1'b0;     tick;
        vecs++;
        if ({start_mem, layer} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL reset_mid_layer1: got mem=%b layer=%0d expected 1 1", start_mem, layer);
        end
        done_mem = 4'b1111; tick;
        done_mem = '0;      tick;
        tick;
        d0 = n_done;
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({start_mem, start_pe, done, busy, err, layer} !== 8'b0) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %b expected 00000000", {start_mem, start_pe, done, busy, err, layer});
        end
        repeat (3) tick;
        @(negedge clk);
        rst = 1'b0;
        tick;
        vecs++;
        if (n_done != d0) begin
            miscompares++;
            $display("FAIL reset_mid_no_done: got %0d extra done expected 0", n_done - d0);
        end
        m0 = n_mem;
        auto_run(3'd1, 50, to);
        vecs++;
        if (to !== 1'b0 || layer !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_mid_rerun: got timeout=%b layer=%0d expected 0 0", to, layer);
        end
        tick;
        vecs++;
        if ((n_mem - m0) != 1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_rerun_count: got mem=%0d busy=%b expected 1 0", n_mem - m0, busy);
        end
    endtask

    task automatic test_watchdog;
        int d0;
        d0 = n_done;
        num_layers = 3'd1; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        done_mem = 4'b1011;
        tick;
        done_mem = '0;
`ifdef CONV_SEQ_WATCHDOG_EN
        repeat (14) tick;
        vecs++;
        if ({done, err} !== 2'b00) begin
            miscompares++;
            $display("FAIL wd_before_limit: got done/err=%b expected 00", {done, err});
        end
        tick;
        vecs++;
        if ({done, err} !== 2'b11) begin
            miscompares++;
            $display("FAIL wd_fire: got done/err=%b expected 11", {done, err});
        end
        tick;
        vecs++;
        if ({busy, err} !== 2'b01) begin
            miscompares++;
            $display("FAIL wd_sticky_err: got busy/err=%b expected 01", {busy, err});
        end
        num_layers = 3'd0; start = 1'b1;
        tick;
        start = 1'b0;
        vecs++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL wd_err_clear: got %b expected 0", err);
        end
        tick;
`else
        repeat (40) tick;
        vecs++;
        if ({busy, start_pe, err} !== 3'b100 || n_done != d0) begin
            miscompares++;
            $display("FAIL no_wd_hold: got busy/pe/err=%b dones=%0d expected 100 0", {busy, start_pe, err}, n_done - d0);
        end
        done_mem = 4'b0100;
        tick;
        done_mem = '0;
        vecs++;
        if (start_pe !== 1'b1) begin
            miscompares++;
            $display("FAIL no_wd_late_bit: got %b expected 1", start_pe);
        end
        tick;
        done_pe = 1'b1;
        tick;
        done_pe = 1'b0;
        vecs++;
        if ({done, err} !== 2'b10) begin
            miscompares++;
            $display("FAIL no_wd_done: got done/err=%b expected 10", {done, err});
        end
        tick;
`endif
    endtask

    initial begin
        test_reset;
        test_two_layer;
        test_same_cycle;
        test_zero_layers;
        test_clamp;
        test_busy_stray;
        test_reset_mid;
        test_watchdog;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_seq.md
# conv_seq

Parametrised multi-layer sequencer for the convolution engine. It runs up to `MAX_LAYERS` layers, each as a memory-load phase followed by a PE phase. The load phase fans out to `NUM_CH` memory channels; the PE phase is a single start/done handshake. It replaces the fixed two-layer control unit and sits between the top-level `start`/`done` handshake and the datapath's per-layer start/done strobes. The layer count is chosen at run time, and an optional watchdog flags a hung datapath.

## Interface
Parameters:
- `MAX_LAYERS`, 4: maximum layers per run (≥1).
- `NUM_CH`, 4: memory channels whose load-done must all be collected per layer.
- `TIMEOUT`, 1024: watchdog limit in cycles per wait phase (used only with the watchdog compiled in).
- Derived: `LW = $clog2(MAX_LAYERS+1)`.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: run request, sampled in IDLE only.
- `num_layers` in LW: layers to run, latched on accepted `start`.
- `done_mem` in NUM_CH: per-channel load-done pulses for the current layer.
- `done_pe` in 1: PE-done pulse for the current layer.
- `start_mem` out 1: one-cycle load-start pulse.
- `start_pe` out 1: one-cycle PE-start pulse.
- `layer` out LW: current layer index.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle run-complete pulse.
- `err` out 1: watchdog error flag; sticky until the next accepted `start`.

## Operation
- States: IDLE, MEM_START, MEM_WAIT, PE_START, PE_WAIT, DONE.
- IDLE + `start`:
  - Latch `n = min(num_layers, MAX_LAYERS)`, set `layer = 0`, clear `err`.
  - If `n == 0`, go to DONE; otherwise go to MEM_START.
- MEM_START: assert `start_mem`, then go to MEM_WAIT.
- Channel collection:
  - A sticky register captures `done_mem` bits in both MEM_START and MEM_WAIT.
  - The exit condition uses `sticky | done_mem`, so bits may arrive in any order, in any cycles, and repeated pulses are harmless.
  - When all `NUM_CH` bits are set, go to PE_START; the sticky register clears on that transition.
- PE_START: assert `start_pe`, then go to PE_WAIT. A `done_pe` arriving during PE_START is captured.
- PE_WAIT, `done_pe` seen:
  - If `layer == n-1`, go to DONE.
  - Otherwise increment `layer` and go to MEM_START.
- DONE: assert `done` for one cycle, then go to IDLE. `layer` holds its last value until the next run.
- Ignored inputs:
  - `start` outside IDLE.
  - `done_mem` outside MEM_START/MEM_WAIT.
  - `done_pe` outside PE_START/PE_WAIT.
- Reset values: state IDLE; `start_mem`, `start_pe`, `done`, `busy`, `err` = 0; `layer` = 0; sticky register = 0.
- Reset mid-run returns to IDLE immediately. No `done` pulse is issued for the aborted run.

## Timing
- `start` high at edge k → `start_mem` and `busy` high in cycle k+1.
- Final channel done at edge j → `start_pe` high in cycle j+1.
- `done_pe` at edge p:
  - Not the last layer: `start_mem` for the next layer in cycle p+1.
  - Last layer: `done` in cycle p+1, `busy` low in cycle p+2.
- `n == 0`: `done` in cycle k+1, with no start strobes.
- All outputs are registered or decoded from state; no input reaches an output combinationally.

## Configuration
- `CONV_SEQ_WATCHDOG_EN` defined:
  - A cycle counter clears on entry to MEM_WAIT and PE_WAIT and increments each cycle in those states.
  - If the counter reaches `TIMEOUT` before the awaited done, set `err` and go to DONE, which still pulses `done`.
- Not defined: no counter is built, `err` is tied to 0, and wait states never exit without their done.

## Structure
- `conv_seq_pkg`: state enum typedef, and the `LW` computation as a function.
- Sub-module `conv_done_collector #(NUM_CH)`:
  - Sticky OR register with clear.
  - `all_done` output computed from `sticky | in`.
- Top FSM, layer counter and the optional watchdog live in `conv_seq`.

## Test plan
- Two-layer run: `num_layers = 2`, `NUM_CH = 4`.
  - Drive `done_mem` bits individually as 4'b0001, 4'b0100, 4'b1000, 4'b0010 on separate cycles, then `done_pe`, for each layer.
  - Expect exactly 2 `start_mem` and 2 `start_pe` pulses, `layer` stepping 0→1, one `done`, `err` = 0.
- Same-cycle completion: `done_mem = 4'b1111` in the MEM_START cycle → `start_pe` exactly two cycles after `start_mem`.
- Boundary layer counts:
  - `num_layers = 0` → `done` at k+1, no strobes.
  - `num_layers = 7` with `MAX_LAYERS = 4` → exactly 4 layers run.
- Busy and stray inputs:
  - `start` re-asserted while busy → ignored.
  - `done_pe` pulsed during MEM_WAIT → ignored; the FSM still waits for all channels.
- Reset in PE_WAIT of layer 1:
  - All outputs return to reset values asynchronously, with no `done`.
  - A fresh `start` then runs normally from layer 0.
- Watchdog (with `CONV_SEQ_WATCHDOG_EN`, `TIMEOUT = 16`): withhold `done_mem[2]` → `err` = 1 and a `done` pulse exactly 16 cycles after MEM_WAIT entry. The next `start` clears `err`.
